// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-side fetch block and its users.
package cpu_pkg;

  // Default address width of the program store (DEPTH = 2**ADDR_W).
  localparam int ADDR_W_DEF = 8;

  // Opcodes with a fixed meaning for the fetch block and the Controller decode.
  localparam logic [7:0] NOP_OPCODE  = 8'h00;
  localparam logic [7:0] HALT_OPCODE = 8'hFF;

  // Fetch-side execution state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage : cpu_pkg

// File: rtl/prog_mem.sv
// Program store: DEPTH x 8, one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a loaded program survives a reset.
module prog_mem #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [7:0]        wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [7:0]        rdData
);

  logic [7:0] mem [DEPTH];

  // Synchronous write of one byte.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wrAddr] <= wrData;
    end
  end

  // Combinational read feeding the registered instruction in the parent.
  assign rdData = mem[rdAddr];

endmodule : prog_mem

// File: rtl/instr_fetch.sv
// Instruction fetch responder: program store, program counter, jump and HALT handling.
//
// Request semantics: LoadIRSig is a single-cycle request sampled at the rising
// edge while in RUN. There is no ready/stall: every sampled request is served,
// and the fetched byte appears on `instruction` in the cycle after the sampling
// edge. instruction and pc hold between requests.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int         DEPTH       = 256,
  parameter int         ADDR_W      = cpu_pkg::ADDR_W_DEF,
  parameter logic [7:0] NOP_OPCODE  = cpu_pkg::NOP_OPCODE,
  parameter logic [7:0] HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              start,
  input  logic              LoadIRSig,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [7:0]        instruction,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              prog_err
);

  state_t            state;
  logic              memWe;
  logic              doFetch;
  logic [ADDR_W-1:0] fetchAddr;
  logic [7:0]        fetchData;
  logic [ADDR_W-1:0] nextPc;

  // Loader writes land only while idle; anywhere else they are flagged as errors.
  assign memWe = prog_we && (state == IDLE);

  // Pick whether this edge loads a new instruction and from which address.
  always_comb begin
    doFetch   = 1'b0;
    fetchAddr = '0;
    unique case (state)
      IDLE: begin
        // A write in the same cycle wins over start.
        doFetch   = start && !prog_we;
        fetchAddr = '0;
      end
      RUN: begin
        doFetch   = LoadIRSig;
        fetchAddr = jump_en ? jump_addr : pc;
      end
      HALTED: begin
        doFetch   = start;
        fetchAddr = '0;
      end
      default: begin
        doFetch   = 1'b0;
        fetchAddr = '0;
      end
    endcase
  end

  // Sequential fetch wraps modulo DEPTH with no error.
  assign nextPc = fetchAddr + 1'b1;

  prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prog_mem (
    .clk    (clk),
    .we     (memWe),
    .wrAddr (prog_addr),
    .wrData (prog_data),
    .rdAddr (fetchAddr),
    .rdData (fetchData)
  );

  // Fetch FSM: state, pc, instruction and status flags all registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= NOP_OPCODE;
      busy        <= 1'b0;
      halted      <= 1'b0;
      prog_err    <= 1'b0;
    end else begin
      prog_err <= prog_we && (state != IDLE);
      if (doFetch) begin
        instruction <= fetchData;
        pc          <= nextPc;
        // A HALT byte stays visible for decode while fetching stops.
        if (fetchData == HALT_OPCODE) begin
          state  <= HALTED;
          busy   <= 1'b0;
          halted <= 1'b1;
        end else begin
          state  <= RUN;
          busy   <= 1'b1;
          halted <= 1'b0;
        end
      end
    end
  end

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch with a transaction-level reference model.
module tb_instr_fetch;

  logic       clk;
  logic       reset;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;
  logic       start;
  logic       LoadIRSig;
  logic       jump_en;
  logic [7:0] jump_addr;
  logic [7:0] instruction;
  logic [7:0] pc;
  logic       busy;
  logic       halted;
  logic       prog_err;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = idle, 1 = running, 2 = halted.
  logic [7:0] mMem [256];
  int         mMode;
  logic [7:0] mPc;
  logic [7:0] mInstr;
  logic       mErr;

  instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .start       (start),
    .LoadIRSig   (LoadIRSig),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .instruction (instruction),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .prog_err    (prog_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    mMode  = 0;
    mPc    = 8'h00;
    mInstr = 8'h00;
    mErr   = 1'b0;
  endtask

  // Serve a fetch from address a: byte appears, pc points past it, FF halts.
  task automatic model_fetch(input logic [7:0] a);
    mInstr = mMem[a];
    mPc    = a + 8'd1;
    mMode  = (mInstr == 8'hFF) ? 2 : 1;
  endtask

  // What one rising edge does, stated from the block's rules.
  task automatic model_edge();
    mErr = prog_we && (mMode != 0);
    if (mMode == 0) begin
      if (prog_we) mMem[prog_addr] = prog_data;
      else if (start) model_fetch(8'h00);
    end else if (mMode == 1) begin
      if (LoadIRSig) model_fetch(jump_en ? jump_addr : mPc);
    end else begin
      if (start) model_fetch(8'h00);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    prog_we   = 1'b0;
    prog_addr = 8'h00;
    prog_data = 8'h00;
    start     = 1'b0;
    LoadIRSig = 1'b0;
    jump_en   = 1'b0;
    jump_addr = 8'h00;
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    idle_inputs();
  endtask

  task automatic write_mem(input logic [7:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    cycle();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
  endtask

  task automatic fetch(input logic jmp, input logic [7:0] ja);
    LoadIRSig = 1'b1; jump_en = jmp; jump_addr = ja;
    cycle();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cycle();
    cycle();
    model_reset();
    reset = 1'b0;
    cycle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if (instruction !== 8'h00 || pc !== 8'h00 || busy !== 1'b0 || halted !== 1'b0 || prog_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got instr=%h pc=%h busy=%b halted=%b err=%b, want 00 00 0 0 0",
               instruction, pc, busy, halted, prog_err);
    end
  endtask

  task automatic test_load_run();
    // Random background program, then the fixed bytes the scenarios rely on.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 254));
      write_mem(8'(i), d);
    end
    write_mem(8'h00, 8'h12);
    write_mem(8'h01, 8'h34);
    write_mem(8'h02, 8'h56);
    write_mem(8'h03, 8'hFF);
    write_mem(8'h04, 8'h11);
    write_mem(8'h80, 8'hA5);
    write_mem(8'hFF, 8'h77);
    pulse_start();
    checks++;
    if (instruction !== 8'h12 || pc !== 8'h01 || busy !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL start_first_fetch: got instr=%h pc=%h busy=%b halted=%b, want 12 01 1 0",
               instruction, pc, busy, halted);
    end
    // Idle cycle between requests: everything holds.
    jump_en = 1'b1; jump_addr = 8'h40;
    cycle();
    checks++;
    if (instruction !== 8'h12 || pc !== 8'h01) begin
      errors++;
      $display("FAIL hold_no_request: got instr=%h pc=%h, want 12 01", instruction, pc);
    end
    for (int k = 0; k < 3; k++) begin
      fetch(1'b0, 8'h00);
      checks++;
      if (instruction !== mInstr || pc !== mPc) begin
        errors++;
        $display("FAIL seq_fetch_%0d: got instr=%h pc=%h, want %h %h", k, instruction, pc, mInstr, mPc);
      end
    end
    checks++;
    if (instruction !== 8'hFF || pc !== 8'h04 || busy !== 1'b0 || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_detect: got instr=%h pc=%h busy=%b halted=%b, want FF 04 0 1",
               instruction, pc, busy, halted);
    end
    fetch(1'b1, 8'h80);
    fetch(1'b0, 8'h00);
    checks++;
    if (instruction !== 8'hFF || pc !== 8'h04 || halted !== 1'b1) begin
      errors++;
      $display("FAIL halted_ignores_fetch: got instr=%h pc=%h halted=%b, want FF 04 1",
               instruction, pc, halted);
    end
  endtask

  task automatic test_restart_from_halt();
    pulse_start();
    checks++;
    if (instruction !== 8'h12 || pc !== 8'h01 || busy !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL restart_from_halt: got instr=%h pc=%h busy=%b halted=%b, want 12 01 1 0",
               instruction, pc, busy, halted);
    end
  endtask

  task automatic test_jump_wrap();
    fetch(1'b0, 8'h00);   // pc now 2
    fetch(1'b1, 8'h80);
    checks++;
    if (instruction !== 8'hA5 || pc !== 8'h81) begin
      errors++;
      $display("FAIL jump_80: got instr=%h pc=%h, want A5 81", instruction, pc);
    end
    fetch(1'b1, 8'hFF);
    checks++;
    if (instruction !== 8'h77 || pc !== 8'h00) begin
      errors++;
      $display("FAIL jump_ff_wrap: got instr=%h pc=%h, want 77 00", instruction, pc);
    end
    fetch(1'b0, 8'h00);
    checks++;
    if (instruction !== 8'h12 || pc !== 8'h01 || busy !== 1'b1) begin
      errors++;
      $display("FAIL after_wrap: got instr=%h pc=%h busy=%b, want 12 01 1", instruction, pc, busy);
    end
  endtask

  task automatic test_illegal_write();
    write_mem(8'h03, 8'h00);
    checks++;
    if (prog_err !== 1'b1) begin
      errors++;
      $display("FAIL err_pulse: got prog_err=%b, want 1", prog_err);
    end
    cycle();
    checks++;
    if (prog_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clears: got prog_err=%b, want 0", prog_err);
    end
    write_mem(8'h03, 8'h00);
    write_mem(8'h03, 8'h00);
    checks++;
    if (prog_err !== 1'b1) begin
      errors++;
      $display("FAIL err_held: got prog_err=%b, want 1", prog_err);
    end
    fetch(1'b1, 8'h03);
    checks++;
    if (instruction !== 8'hFF || halted !== 1'b1 || pc !== 8'h04) begin
      errors++;
      $display("FAIL mem3_kept: got instr=%h halted=%b pc=%h, want FF 1 04", instruction, halted, pc);
    end
  endtask

  task automatic test_start_with_write();
    apply_reset();
    prog_we = 1'b1; prog_addr = 8'h10; prog_data = 8'h5A; start = 1'b1;
    cycle();
    checks++;
    if (busy !== 1'b0 || instruction !== 8'h00 || pc !== 8'h00) begin
      errors++;
      $display("FAIL start_we_idle: got busy=%b instr=%h pc=%h, want 0 00 00", busy, instruction, pc);
    end
    pulse_start();
    fetch(1'b1, 8'h10);
    checks++;
    if (instruction !== 8'h5A || pc !== 8'h11) begin
      errors++;
      $display("FAIL start_we_wrote: got instr=%h pc=%h, want 5A 11", instruction, pc);
    end
  endtask

  task automatic test_async_reset();
    fetch(1'b1, 8'h04);
    checks++;
    if (pc !== 8'h05 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_pc5: got pc=%h busy=%b, want 05 1", pc, busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (instruction !== 8'h00 || pc !== 8'h00 || busy !== 1'b0 || halted !== 1'b0 || prog_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got instr=%h pc=%h busy=%b halted=%b err=%b, want 00 00 0 0 0",
               instruction, pc, busy, halted, prog_err);
    end
    cycle();
    model_reset();
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    pulse_start();
    for (int n = 0; n < 400; n++) begin
      LoadIRSig = 1'($urandom_range(0, 1));
      jump_en   = ($urandom_range(0, 3) == 0);
      jump_addr = 8'($urandom_range(0, 255));
      prog_we   = ($urandom_range(0, 15) == 0);
      prog_addr = 8'($urandom_range(0, 255));
      prog_data = 8'($urandom_range(0, 255));
      start     = !prog_we && ($urandom_range(0, 7) == 0);
      cycle();
      checks++;
      if (instruction !== mInstr || pc !== mPc || busy !== (mMode == 1) ||
          halted !== (mMode == 2) || prog_err !== mErr) begin
        errors++;
        $display("FAIL random_%0d: got instr=%h pc=%h busy=%b halted=%b err=%b, want %h %h %b %b %b",
                 n, instruction, pc, busy, halted, prog_err,
                 mInstr, mPc, (mMode == 1), (mMode == 2), mErr);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_load_run();
    test_restart_from_halt();
    test_jump_wrap();
    test_illegal_write();
    test_start_with_write();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_instr_fetch

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Program-memory and fetch responder on the instruction side of the CPU.
- Answers the CPU's LoadIRSig request by presenting the next 8-bit instruction on `instruction`, one cycle later.
- Holds an internal program store that a loader writes while the block is idle, plus a program counter with wrap-around, jump support and HALT detection.
- Sits beside the CPU in the top-level test harness: `instruction` drives CPU.instruction, and CPU.LoadIRSig drives this block.

Parameters:
- DEPTH, 256, number of 8-bit program locations.
- ADDR_W, 8, width of pc, prog_addr and jump_addr; DEPTH = 2**ADDR_W.
- NOP_OPCODE, 8'h00, value driven on `instruction` when idle or after reset.
- HALT_OPCODE, 8'hFF, fetched value that stops fetching.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- prog_we  in  1  program-store write enable; honoured only in IDLE.
- prog_addr  in  ADDR_W  write address.
- prog_data  in  8  write data.
- start  in  1  one-cycle pulse that begins execution from address 0.
- LoadIRSig  in  1  fetch request from the CPU, sampled at the rising edge.
- jump_en  in  1  the next fetch comes from jump_addr instead of pc.
- jump_addr  in  ADDR_W  jump target.
- instruction  out  8  registered instruction presented to the CPU.
- pc  out  ADDR_W  address of the next sequential fetch.
- busy  out  1  high in RUN.
- halted  out  1  high in HALTED.
- prog_err  out  1  one-cycle pulse when prog_we is asserted outside IDLE.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is asynchronous and active-high.
- Reset values (asynchronous): state=IDLE, pc=0, instruction=NOP_OPCODE, busy=0, halted=0, prog_err=0.
  - The program store is NOT cleared by reset.
  - Reset asserted mid-RUN aborts immediately to these values.
- Program store: DEPTH x 8 array, synchronous write, combinational read into the registered `instruction`.
- State IDLE:
  - prog_we=1: mem[prog_addr] <= prog_data.
  - start=1 with prog_we=0: next edge gives instruction <= mem[0], pc <= 1, state -> RUN.
  - start and prog_we high in the same cycle: the write happens, start is ignored, state stays IDLE.
  - LoadIRSig and jump_en are ignored.
- State RUN, on an edge where LoadIRSig=1:
  - jump_en=1: instruction <= mem[jump_addr], pc <= jump_addr+1.
  - jump_en=0: instruction <= mem[pc], pc <= pc+1.
  - pc arithmetic is modulo DEPTH: 8'hFF+1 -> 8'h00. There is no error on wrap.
  - Latency: the fetched byte is valid on `instruction` in the cycle after the sampling edge.
  - LoadIRSig=0: instruction and pc hold.
  - jump_en without LoadIRSig has no effect.
- HALT detection: if the byte loaded into `instruction` equals HALT_OPCODE, the same edge moves state to HALTED.
  - HALT_OPCODE stays on `instruction` so the CPU decodes it.
  - pc is still incremented normally.
- State HALTED:
  - LoadIRSig and jump_en are ignored; instruction and pc hold.
  - start=1: same action as start in IDLE (restart from address 0).
  - prog_we is illegal here.
  - Only reset returns the block to IDLE.
- Illegal writes: prog_we=1 in RUN or HALTED does not write, and prog_err=1 for exactly the next cycle. If prog_we is held, prog_err stays high each cycle.
- start in RUN is ignored (no restart).
- Status outputs: busy = (state==RUN) and halted = (state==HALTED), both registered with the state.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum {IDLE, RUN, HALTED};
  - NOP_OPCODE and HALT_OPCODE constants, reused by Controller decode;
  - the ADDR_W default.
- One sub-module is natural: prog_mem (DEPTH x 8, single synchronous write port, single combinational read port). The FSM and pc logic stay in instr_fetch.

Test Plan:
- Reset with the block idle -> instruction=8'h00, pc=0, busy=0, halted=0. Reset is re-asserted asynchronously mid-RUN at pc=5 -> all outputs return to reset values within the same cycle, with no clock edge needed.
- Load mem[0..3]={8'h12,8'h34,8'h56,8'hFF}, pulse start -> next cycle instruction=8'h12, pc=1, busy=1. Three LoadIRSig pulses -> 8'h34, 8'h56, 8'hFF, each one cycle after its request. halted=1 and busy=0 after the FF. Further LoadIRSig leaves instruction=8'hFF and pc=4.
- In RUN at pc=2, LoadIRSig=1 with jump_en=1 and jump_addr=8'h80 (mem[8'h80]=8'hA5) -> instruction=8'hA5, pc=8'h81.
- Jump to 8'hFF with mem[8'hFF]=8'h77 -> pc=8'h00. The next fetch returns mem[0]=8'h12 and pc=1 (wrap-around).
- prog_we=1 during RUN at addr 3 with data 8'h00 -> prog_err pulses one cycle and mem[3] stays 8'hFF. start and prog_we together in IDLE -> write lands, state stays IDLE, busy=0.
- From HALTED, pulse start -> instruction=mem[0]=8'h12, pc=1, busy=1, halted=0.
